// File: rtl/lib_cpu.sv
// Shared CPU-side definitions: UART frame states and data width.
package lib_cpu;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } UART_STATE;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: latches a byte on w_en and shifts it out LSB first.
module uart_tx_core
    import lib_cpu::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_en,
    input  logic [UART_DATA_BITS-1:0] w_data,
    output logic                      tx,
    output logic                      busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    UART_STATE                 r_state;
    logic [BW-1:0]             r_baud;
    logic [2:0]                r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      w_baud_done;

    assign w_baud_done = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (w_en) begin
                        r_shift <= w_data;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == BIT_LAST) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (r_state)
            START:   tx = 1'b0;
            DATA:    tx = r_shift[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy = (r_state != IDLE);

endmodule

// File: rtl/uart_io.sv
// CPU-side serial port: TX via uart_tx_core, RX deserializer with irr/overrun bookkeeping.
module uart_io
    import lib_cpu::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_en,
    input  logic [7:0]  w_data,
    input  logic        r_ack,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        w_busy,
    output logic [31:0] r_data,
    output logic        irr,
    output logic        overrun
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    // IDLE's detection cycle counts as the first of the CLKS_PER_BIT/2 half-bit cycles.
    localparam logic [BW-1:0] BAUD_MID = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    UART_STATE                 r_rx_state;
    logic [BW-1:0]             r_rx_baud;
    logic [2:0]                r_rx_bit;
    logic [UART_DATA_BITS-1:0] r_rx_shift;
    logic                      w_rx_baud_done;
    logic                      w_rx_valid;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .w_en  (w_en),
        .w_data(w_data),
        .tx    (uart_tx),
        .busy  (w_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_baud_done = (r_rx_baud == BAUD_LAST);
    assign w_rx_valid     = (r_rx_state == STOP) && w_rx_baud_done && r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= IDLE;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            unique case (r_rx_state)
                IDLE: begin
                    r_rx_baud <= '0;
                    if (!r_sync2) begin
                        r_rx_state <= START;
                    end
                end
                START: begin
                    if (r_rx_baud == BAUD_MID) begin
                        r_rx_baud  <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_sync2 ? IDLE : DATA;
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_rx_baud_done) begin
                        r_rx_baud  <= '0;
                        r_rx_shift <= {r_sync2, r_rx_shift[UART_DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == BIT_LAST) begin
                            r_rx_state <= STOP;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop on both outcomes so the next start edge is seen.
                    if (w_rx_baud_done) begin
                        r_rx_baud  <= '0;
                        r_rx_state <= IDLE;
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            irr     <= 1'b0;
            overrun <= 1'b0;
        end else if (w_rx_valid) begin
            r_data  <= {{(32 - UART_DATA_BITS){1'b0}}, r_rx_shift};
            irr     <= 1'b1;
            overrun <= r_ack ? 1'b0 : (overrun | irr);
        end else if (r_ack) begin
            irr     <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
